// File: rtl/controller_sequencer.sv
// -----------------------------------------------------------------------------
// controller_sequencer
//
// Control unit of the 8-bit SAP datapath. A six-state one-hot ring counter
// (T1..T6) is combined with the instruction-register opcode to produce the
// control word for every bus master and loader. HLT freezes the machine until
// clr is pulled low.
//
// Ports
//   clk      in   system clock, all state changes on posedge
//   clr      in   asynchronous active-low reset; also gates every output
//   opcode   in   [3:0] upper IR nibble, used during T4..T6 only
//   Cp, Ep   out  program counter count enable / bus drive
//   Lm       out  MAR load
//   CE       out  RAM bus drive
//   Li, Ei   out  IR load / IR address nibble bus drive
//   La, Ea   out  accumulator load / bus drive
//   Su, Eu   out  ALU subtract select / bus drive
//   Lb       out  B register load
//   Lo       out  output register load
//   hlt      out  machine halted
//   t_state  out  [5:0] one-hot ring state (bit0 = T1), zero while halted/reset
// -----------------------------------------------------------------------------
module controller_sequencer #(
   parameter logic [3:0] OP_LDA = 4'b0000,
   parameter logic [3:0] OP_ADD = 4'b0001,
   parameter logic [3:0] OP_SUB = 4'b0010,
   parameter logic [3:0] OP_OUT = 4'b1110,
   parameter logic [3:0] OP_HLT = 4'b1111
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] opcode,
   output logic       Cp,
   output logic       Ep,
   output logic       Lm,
   output logic       CE,
   output logic       Li,
   output logic       Ei,
   output logic       La,
   output logic       Ea,
   output logic       Su,
   output logic       Eu,
   output logic       Lb,
   output logic       Lo,
   output logic       hlt,
   output logic [5:0] t_state
);

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   logic [5:0] ring_reg;
   logic [5:0] ring_next;
   logic       halt_reg;
   logic       halt_next;

   // Outputs are live only when out of reset and not halted; gating with clr
   // makes the control word drop the instant clr falls, not at the next edge.
   logic       run_en;
   assign run_en = clr & ~halt_reg;

   logic is_lda, is_add, is_sub, is_out;
   assign is_lda = (opcode == OP_LDA);
   assign is_add = (opcode == OP_ADD);
   assign is_sub = (opcode == OP_SUB);
   assign is_out = (opcode == OP_OUT);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         ring_reg <= T1;
         halt_reg <= 1'b0;
      end else begin
         ring_reg <= ring_next;
         halt_reg <= halt_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      ring_next = ring_reg;
      halt_next = halt_reg;
      if (!halt_reg) begin
         case (ring_reg)
            T1: ring_next = T2;
            T2: ring_next = T3;
            T3: ring_next = T4;
            T4: begin
               // HLT parks the ring at T4; t_state is masked while halted.
               if (opcode == OP_HLT) begin
                  halt_next = 1'b1;
               end else begin
                  ring_next = T5;
               end
            end
            T5: ring_next = T6;
            T6: ring_next = T1;
            // Any corrupted, non-one-hot value restarts the instruction.
            default: ring_next = T1;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Control word decode
   // -------------------------------------------------------------------------
   always_comb begin
      Cp = 1'b0;
      Ep = 1'b0;
      Lm = 1'b0;
      CE = 1'b0;
      Li = 1'b0;
      Ei = 1'b0;
      La = 1'b0;
      Ea = 1'b0;
      Su = 1'b0;
      Eu = 1'b0;
      Lb = 1'b0;
      Lo = 1'b0;
      if (run_en) begin
         case (ring_reg)
            T1: begin
               Ep = 1'b1;
               Lm = 1'b1;
            end
            T2: begin
               Cp = 1'b1;
            end
            T3: begin
               CE = 1'b1;
               Li = 1'b1;
            end
            T4: begin
               if (is_lda || is_add || is_sub) begin
                  Ei = 1'b1;
                  Lm = 1'b1;
               end else if (is_out) begin
                  Ea = 1'b1;
                  Lo = 1'b1;
               end
            end
            T5: begin
               if (is_lda) begin
                  CE = 1'b1;
                  La = 1'b1;
               end else if (is_add || is_sub) begin
                  CE = 1'b1;
                  Lb = 1'b1;
               end
            end
            T6: begin
               if (is_add || is_sub) begin
                  Eu = 1'b1;
                  La = 1'b1;
                  Su = is_sub;
               end
            end
            default: ;
         endcase
      end
   end

   assign hlt = clr & halt_reg;

   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_tstate
         assign t_state[gi] = ring_reg[gi] & run_en;
      end
   endgenerate

endmodule
